// File: rtl/yolo_ofm_axi_writer_pkg.sv
// Shared constants and types for the YOLO OFM write-back DMA.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: AXI field constants, 4 KB page size, FSM state encoding and a
// helper that returns how many 32-bit words remain before the next 4 KB page.
package yolo_ofm_axi_writer_pkg;

  localparam logic [2:0] AXSIZE_4B    = 3'b010;
  localparam logic [1:0] AXBURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam int         PAGE_BYTES   = 4096;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_ADDR      = 3'd2,
    ST_DATA      = 3'd3,
    ST_RESP      = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  // Words left in the current 4 KB page for a word-aligned byte offset (1..1024).
  function automatic logic [10:0] page_words_left(input logic [11:0] page_off);
    logic [12:0] bytes_left;
    bytes_left = 13'(PAGE_BYTES) - {1'b0, page_off};
    return bytes_left[12:2];
  endfunction

endpackage

// File: rtl/yolo_sync_fifo.sv
// Synchronous first-word fall-through FIFO buffering OFM words.
// Latency: a pushed word is visible on head the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; full/empty/count exported.
// Ports: clk, rst (async active-high), push/push_data, pop, head, full, empty, count.
module yolo_sync_fifo #(
  parameter  int DEPTH = 32,
  parameter  int DW    = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/yolo_ofm_axi_writer.sv
// OFM write-back DMA: buffers a word stream and writes it to DRAM as AXI INCR bursts.
// Latency: a burst starts once it is fully buffered; one AXI transaction outstanding at a time.
// Backpressure: s_ready drops when the FIFO is full or num_words have been accepted; W never stalls for data.
// Ports: clk/rst, i_start/i_base_addr/i_num_words (layer setup), s_* (OFM stream in),
//        M_AW*/M_W*/M_B* (AXI write master), o_busy/o_done/o_err (status).
module yolo_ofm_axi_writer
  import yolo_ofm_axi_writer_pkg::*;
#(
  parameter int AXI_WIDTH_AD = 32,
  parameter int AXI_WIDTH_ID = 4,
  parameter int AXI_WIDTH_DA = 32,
  parameter int AXI_WIDTH_DS = 4,
  parameter int BURST_LEN    = 16,
  parameter int FIFO_DEPTH   = 32,
  parameter int CNT_W        = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic [AXI_WIDTH_AD-1:0] i_base_addr,
  input  logic [CNT_W-1:0]        i_num_words,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [AXI_WIDTH_DA-1:0] s_data,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [AXI_WIDTH_AD-1:0] M_AWADDR,
  output logic [AXI_WIDTH_ID-1:0] M_AWID,
  output logic [7:0]              M_AWLEN,
  output logic [2:0]              M_AWSIZE,
  output logic [1:0]              M_AWBURST,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  output logic [AXI_WIDTH_DA-1:0] M_WDATA,
  output logic [AXI_WIDTH_DS-1:0] M_WSTRB,
  output logic                    M_WLAST,
  output logic [AXI_WIDTH_ID-1:0] M_WID,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  input  logic [1:0]              M_BRESP,
  input  logic [AXI_WIDTH_ID-1:0] M_BID,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  localparam int FA = $clog2(FIFO_DEPTH);

  state_t                  state;
  state_t                  state_nxt;
  logic [AXI_WIDTH_AD-1:0] addr;
  logic [CNT_W-1:0]        num_words;
  logic [CNT_W-1:0]        words_rem;
  logic [CNT_W-1:0]        accepted;
  logic [CNT_W-1:0]        blen;
  logic [CNT_W-1:0]        blen_calc;
  logic [CNT_W-1:0]        page_left;
  logic [CNT_W-1:0]        beat;
  logic [FA:0]             fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [AXI_WIDTH_DA-1:0] fifo_head;
  logic                    push;
  logic                    pop;
  logic                    last_beat;
  logic                    status_unused;

  // B ID is not needed with a single outstanding transaction.
  assign status_unused = ^{M_BID, fifo_empty};

  assign push = s_valid && s_ready;
  assign pop  = M_WVALID && M_WREADY;

  yolo_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (AXI_WIDTH_DA)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next burst length: burst cap, remaining words and distance to the 4 KB page end.
  assign page_left = CNT_W'(page_words_left(addr[11:0]));

  always_comb begin
    blen_calc = CNT_W'(BURST_LEN);
    if (words_rem < blen_calc) blen_calc = words_rem;
    if (page_left < blen_calc) blen_calc = page_left;
  end

  assign last_beat = (beat == blen - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    M_AWVALID = 1'b0;
    M_WVALID  = 1'b0;
    M_WLAST   = 1'b0;
    M_BREADY  = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) state_nxt = (i_num_words == '0) ? ST_DONE : ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        o_busy = 1'b1;
        // Whole burst must be buffered so WVALID never drops mid-burst.
        if (CNT_W'(fifo_count) >= blen_calc) state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        o_busy    = 1'b1;
        M_AWVALID = 1'b1;
        if (M_AWREADY) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        o_busy   = 1'b1;
        M_WVALID = 1'b1;
        M_WLAST  = last_beat;
        if (M_WREADY && last_beat) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        o_busy   = 1'b1;
        M_BREADY = 1'b1;
        if (M_BVALID) state_nxt = (words_rem == blen) ? ST_DONE : ST_WAIT_DATA;
      end
      ST_DONE: begin
        o_done    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      num_words <= '0;
      words_rem <= '0;
      accepted  <= '0;
      blen      <= '0;
      beat      <= '0;
      o_err     <= 1'b0;
    end else begin
      if (state == ST_IDLE && i_start) begin
        addr      <= i_base_addr;
        num_words <= i_num_words;
        words_rem <= i_num_words;
        accepted  <= '0;
        o_err     <= 1'b0;
      end
      if (push) accepted <= accepted + CNT_W'(1);
      // Freeze the burst length so AW fields and the beat count stay consistent.
      if (state == ST_WAIT_DATA && state_nxt == ST_ADDR) blen <= blen_calc;
      if (state == ST_ADDR && M_AWREADY) beat <= '0;
      if (pop) beat <= beat + CNT_W'(1);
      if (state == ST_RESP && M_BVALID) begin
        if (M_BRESP != RESP_OKAY) o_err <= 1'b1;
        addr      <= addr + AXI_WIDTH_AD'({blen, 2'b00});
        words_rem <= words_rem - blen;
      end
    end
  end

  assign s_ready   = o_busy && !fifo_full && (accepted < num_words);

  assign M_AWADDR  = addr;
  assign M_AWID    = '0;
  assign M_AWLEN   = (state == ST_ADDR) ? 8'(blen - CNT_W'(1)) : 8'd0;
  assign M_AWSIZE  = AXSIZE_4B;
  assign M_AWBURST = AXBURST_INCR;
  assign M_WDATA   = (state == ST_DATA) ? fifo_head : '0;
  assign M_WSTRB   = '1;
  assign M_WID     = '0;

endmodule

// File: tb/tb_yolo_ofm_axi_writer.sv
module tb_yolo_ofm_axi_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [31:0] i_base_addr;
  logic [19:0] i_num_words;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        M_AWVALID, M_AWREADY;
  logic [31:0] M_AWADDR;
  logic [3:0]  M_AWID;
  logic [7:0]  M_AWLEN;
  logic [2:0]  M_AWSIZE;
  logic [1:0]  M_AWBURST;
  logic        M_WVALID, M_WREADY;
  logic [31:0] M_WDATA;
  logic [3:0]  M_WSTRB;
  logic        M_WLAST;
  logic [3:0]  M_WID;
  logic        M_BVALID, M_BREADY;
  logic [1:0]  M_BRESP;
  logic [3:0]  M_BID;
  logic        o_busy, o_done, o_err;

  always #5 clk = ~clk;

  yolo_ofm_axi_writer dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_num_words(i_num_words), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_AWADDR(M_AWADDR), .M_AWID(M_AWID),
    .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE), .M_AWBURST(M_AWBURST),
    .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB),
    .M_WLAST(M_WLAST), .M_WID(M_WID), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_BRESP(M_BRESP), .M_BID(M_BID), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard queues
  logic [31:0] exp_awaddr[$];
  logic [7:0]  exp_awlen[$];
  bit          exp_wlast[$];
  logic [31:0] exp_data[$];

  // Slave / monitor state
  int  aw_delay   = 0;
  bit  wr_toggle  = 0;
  bit  sv_random  = 0;
  int  err_burst  = -1;
  int  bnum       = 0;
  int  b_pending  = 0;
  bit  b_hs       = 0;
  int  aw_cnt     = 0;
  int  w_beats    = 0;
  int  done_cnt   = 0;
  bit  aw_hold    = 0;
  bit  w_hold     = 0;
  logic [31:0] hold_awaddr, hold_wdata;
  logic [7:0]  hold_awlen;
  logic        hold_wlast;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: samples on the falling edge, i.e. the values the next rising edge transfers.
  always @(negedge clk) begin
    if (rst) begin
      aw_hold = 0;
      w_hold  = 0;
    end else begin
      if (aw_hold) begin
        check("aw_valid_held", M_AWVALID, 1'b1);
        check("aw_addr_stable", M_AWADDR, hold_awaddr);
        check("aw_len_stable", M_AWLEN, hold_awlen);
      end
      aw_hold     = M_AWVALID && !M_AWREADY;
      hold_awaddr = M_AWADDR;
      hold_awlen  = M_AWLEN;
      if (M_AWVALID && M_AWREADY) begin
        check("aw_expected", exp_awaddr.size() != 0, 1'b1);
        if (exp_awaddr.size() != 0) begin
          check("awaddr", M_AWADDR, exp_awaddr.pop_front());
          check("awlen", M_AWLEN, exp_awlen.pop_front());
        end
        check("awsize_awburst", {M_AWSIZE, M_AWBURST}, {3'b010, 2'b01});
        aw_cnt++;
      end

      if (w_hold) begin
        check("w_valid_held", M_WVALID, 1'b1);
        check("wdata_stable", M_WDATA, hold_wdata);
        check("wlast_stable", M_WLAST, hold_wlast);
      end
      w_hold     = M_WVALID && !M_WREADY;
      hold_wdata = M_WDATA;
      hold_wlast = M_WLAST;
      if (M_WVALID && M_WREADY) begin
        check("w_expected", (exp_wlast.size() != 0) && (exp_data.size() != 0), 1'b1);
        if (exp_wlast.size() != 0) check("wlast", M_WLAST, exp_wlast.pop_front());
        if (exp_data.size() != 0)  check("wdata", M_WDATA, exp_data.pop_front());
        check("wstrb", M_WSTRB, 4'hF);
        w_beats++;
        if (M_WLAST) b_pending++;
      end

      if (M_BVALID && M_BREADY) b_hs = 1;
      if (o_done) done_cnt++;
    end
  end

  // AW slave: AWREADY after aw_delay cycles of AWVALID.
  initial begin
    int aw_wait;
    aw_wait   = 0;
    M_AWREADY = 0;
    forever begin
      @(posedge clk); #1;
      if (M_AWVALID && !M_AWREADY) begin
        if (aw_wait >= aw_delay) M_AWREADY = 1;
        else aw_wait++;
      end else begin
        M_AWREADY = 0;
        aw_wait   = 0;
      end
    end
  end

  // W slave: always ready or toggling.
  initial begin
    M_WREADY = 1;
    forever begin
      @(posedge clk); #1;
      M_WREADY = wr_toggle ? ~M_WREADY : 1'b1;
    end
  end

  // B slave: one response per completed burst.
  initial begin
    M_BVALID = 0;
    M_BRESP  = 2'b00;
    M_BID    = 4'h0;
    forever begin
      @(posedge clk); #1;
      if (b_hs) begin
        M_BVALID = 0;
        b_hs     = 0;
      end else if (b_pending > 0 && !M_BVALID) begin
        M_BVALID = 1;
        M_BRESP  = (bnum == err_burst) ? 2'b10 : 2'b00;
        b_pending--;
        bnum++;
      end
    end
  end

  task automatic push_model(input logic [31:0] base, input int num);
    logic [31:0] a;
    int rem, bl, pg;
    a   = base;
    rem = num;
    while (rem > 0) begin
      pg = (4096 - int'(a[11:0])) / 4;
      bl = 16;
      if (rem < bl) bl = rem;
      if (pg < bl) bl = pg;
      exp_awaddr.push_back(a);
      exp_awlen.push_back(8'(bl - 1));
      for (int i = 0; i < bl; i++) exp_wlast.push_back(i == bl - 1);
      a   = a + 32'(4 * bl);
      rem = rem - bl;
    end
  endtask

  task automatic do_start(input logic [31:0] base, input int num);
    i_base_addr = base;
    i_num_words = 20'(num);
    i_start     = 1;
    @(posedge clk); #1;
    i_start     = 0;
  endtask

  task automatic stream(input string tag, input int num, input logic [31:0] dbase);
    int k, t;
    k = 0;
    t = 0;
    while (k < num && t < 5000) begin
      s_valid = sv_random ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = dbase + 32'(k);
      @(negedge clk);
      if (s_valid && s_ready) begin
        exp_data.push_back(s_data);
        k++;
      end
      @(posedge clk); #1;
      t++;
    end
    s_valid = 0;
    check({tag, "_accepted"}, k, num);
    // A word beyond num_words must be refused.
    s_valid = 1;
    s_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    check({tag, "_extra_refused"}, s_ready, 1'b0);
    @(posedge clk); #1;
    s_valid = 0;
  endtask

  task automatic wait_done(input string tag, input int prev);
    int t;
    t = 0;
    while (done_cnt == prev && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_once"}, done_cnt, prev + 1);
    check({tag, "_busy_low"}, o_busy, 1'b0);
    check({tag, "_aw_drained"}, exp_awaddr.size(), 0);
    check({tag, "_w_drained"}, exp_wlast.size(), 0);
    check({tag, "_data_drained"}, exp_data.size(), 0);
  endtask

  task automatic run_layer(input string tag, input logic [31:0] base, input int num,
                           input logic [31:0] dbase, input bit retrigger);
    int prev;
    prev = done_cnt;
    push_model(base, num);
    do_start(base, num);
    check({tag, "_busy"}, o_busy, 1'b1);
    check({tag, "_err_cleared"}, o_err, 1'b0);
    if (retrigger) begin
      // A start while busy must not disturb the layer in flight.
      do_start(32'h0000_8000, 3);
      i_base_addr = base;
    end
    stream(tag, num, dbase);
    wait_done(tag, prev);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_awvalid"}, M_AWVALID, 1'b0);
    check({tag, "_wvalid"}, M_WVALID, 1'b0);
    check({tag, "_wlast"}, M_WLAST, 1'b0);
    check({tag, "_bready"}, M_BREADY, 1'b0);
    check({tag, "_s_ready"}, s_ready, 1'b0);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_done"}, o_done, 1'b0);
    check({tag, "_err"}, o_err, 1'b0);
    check({tag, "_awaddr"}, M_AWADDR, 32'h0);
  endtask

  initial begin
    int prev, base_beats, t, aw_before;
    rst         = 1;
    i_start     = 0;
    i_base_addr = 0;
    i_num_words = 0;
    s_valid     = 0;
    s_data      = 0;
    #1;
    check_quiet("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk); #1;

    // Single full burst, data 0..15
    run_layer("t1", 32'h0000_1000, 16, 32'h0, 1'b0);
    check("t1_aw_count", aw_cnt, 1);
    check("t1_err", o_err, 1'b0);

    // Three bursts 16/16/8, data 0..39, with a start pulse while busy
    run_layer("t2", 32'h0000_1000, 40, 32'h0, 1'b1);
    check("t2_aw_count", aw_cnt, 4);

    // 4 KB boundary split: 0xFF8 LEN1 then 0x1000 LEN1
    run_layer("t3", 32'h0000_0FF8, 4, 32'h0000_0100, 1'b0);
    check("t3_aw_count", aw_cnt, 6);

    // Stalls: toggling WREADY, late AWREADY, bursty source
    wr_toggle = 1;
    aw_delay  = 5;
    sv_random = 1;
    run_layer("t4", 32'h0000_3000, 40, 32'hA000_0000, 1'b0);
    wr_toggle = 0;
    aw_delay  = 0;
    sv_random = 0;
    @(posedge clk); #1;

    // Error on first of two bursts: sticky, both bursts still written
    err_burst = bnum;
    run_layer("t5", 32'h0000_2000, 32, 32'hB000_0000, 1'b0);
    check("t5_err_sticky", o_err, 1'b1);
    check("t5_aw_count", aw_cnt, 11);
    err_burst = -1;

    // Reset during beat 7 of a 16-beat burst
    push_model(32'h0000_4000, 16);
    do_start(32'h0000_4000, 16);
    check("t6_err_cleared_by_start", o_err, 1'b0);
    base_beats = w_beats;
    stream("t6", 16, 32'hC000_0000);
    t = 0;
    while (w_beats - base_beats < 7 && t < 500) begin
      @(posedge clk); #2;
      t++;
    end
    check("t6_reached_beat7", w_beats - base_beats, 7);
    rst = 1;
    #1;
    check_quiet("midreset");
    exp_awaddr.delete();
    exp_awlen.delete();
    exp_wlast.delete();
    exp_data.delete();
    b_pending = 0;
    b_hs      = 0;
    M_BVALID  = 0;
    s_valid   = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_beats_after_reset", w_beats - base_beats, 7);
    check("t6_awvalid_after_reset", M_AWVALID, 1'b0);

    // Zero-word layer: done without any AW
    aw_before = aw_cnt;
    prev      = done_cnt;
    do_start(32'h0000_5000, 0);
    wait_done("t7", prev);
    check("t7_no_aw", aw_cnt, aw_before);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
